// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, cmov/jXX condition, and the E->M pipeline register.
// Combinational results are valid in the same cycle and registered into M on the next edge. There is no backpressure; bubble_m squashes the M load.
module execute_stage #(
  parameter int         W     = 64,
  parameter logic [3:0] RNONE = 4'hF,
  parameter logic [3:0] RRSP  = 4'h4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   stat_e,
  input  logic [3:0]   icode_e,
  input  logic [3:0]   ifun_e,
  input  logic [3:0]   rA_e,
  input  logic [3:0]   rB_e,
  input  logic [W-1:0] valA_e,
  input  logic [W-1:0] valB_e,
  input  logic [W-1:0] valc_e,
  input  logic [2:0]   m_stat_in,
  input  logic [2:0]   w_stat_in,
  input  logic         bubble_m,
  output logic [W-1:0] valE_e,
  output logic [3:0]   dstE_e,
  output logic         cnd_e,
  output logic         zf,
  output logic         sf,
  output logic         of,
  output logic [2:0]   stat_m,
  output logic [3:0]   icode_m,
  output logic         cnd_m,
  output logic [W-1:0] valE_m,
  output logic [W-1:0] valA_m,
  output logic [3:0]   dstE_m,
  output logic [3:0]   dstM_m
);

  localparam logic [2:0] S_AOK = 3'd1, S_HLT = 3'd2, S_ADR = 3'd3, S_INS = 3'd4;
  localparam logic [3:0] I_NOP = 4'h1, I_CMOV = 4'h2, I_IRMOV = 4'h3, I_RMMOV = 4'h4,
                         I_MRMOV = 4'h5, I_OP = 4'h6, I_JXX = 4'h7, I_CALL = 4'h8,
                         I_RET = 4'h9, I_PUSH = 4'hA, I_POP = 4'hB;
  localparam logic [W-1:0] POS8 = W'(8);
  localparam logic [W-1:0] NEG8 = ~W'(7);

  logic [W-1:0] alu_a, alu_b;
  logic [3:0]   alu_fn;
  logic         new_of, set_cc, cond;
  logic [3:0]   dstm_e;

  always_comb begin
    alu_a = '0;
    case (icode_e)
      I_CMOV, I_OP:             alu_a = valA_e;
      I_IRMOV, I_RMMOV, I_MRMOV: alu_a = valc_e;
      I_CALL, I_PUSH:           alu_a = NEG8;
      I_RET, I_POP:             alu_a = POS8;
      default:                  alu_a = '0;
    endcase
    alu_b = '0;
    case (icode_e)
      I_RMMOV, I_MRMOV, I_OP, I_CALL, I_RET, I_PUSH, I_POP: alu_b = valB_e;
      default:                                              alu_b = '0;
    endcase
  end

  // Overflow is computed from the operand/result sign bits for the selected operation.
  always_comb begin
    alu_fn = (icode_e == I_OP) ? ifun_e : 4'h0;
    valE_e = alu_a + alu_b;
    new_of = (alu_a[W-1] == alu_b[W-1]) && (valE_e[W-1] != alu_a[W-1]);
    case (alu_fn)
      4'h1: begin
        valE_e = alu_b - alu_a;
        new_of = (alu_a[W-1] != alu_b[W-1]) && (valE_e[W-1] != alu_b[W-1]);
      end
      4'h2: begin
        valE_e = alu_a & alu_b;
        new_of = 1'b0;
      end
      4'h3: begin
        valE_e = alu_a ^ alu_b;
        new_of = 1'b0;
      end
      default: ;
    endcase
  end

  // A faulting instruction further down the pipe must not let a younger OPq update CC.
  assign set_cc = (icode_e == I_OP) && (stat_e == S_AOK) &&
                  !(m_stat_in inside {S_HLT, S_ADR, S_INS}) &&
                  !(w_stat_in inside {S_HLT, S_ADR, S_INS});

  always_comb begin
    cond = 1'b0;
    case (ifun_e)
      4'h0:    cond = 1'b1;
      4'h1:    cond = (sf ^ of) | zf;
      4'h2:    cond = sf ^ of;
      4'h3:    cond = zf;
      4'h4:    cond = ~zf;
      4'h5:    cond = ~(sf ^ of);
      4'h6:    cond = ~(sf ^ of) & ~zf;
      default: cond = 1'b0;
    endcase
    cnd_e = (icode_e == I_CMOV || icode_e == I_JXX) ? cond : 1'b1;
  end

  always_comb begin
    dstE_e = RNONE;
    case (icode_e)
      I_IRMOV, I_OP:                 dstE_e = rB_e;
      I_CMOV:                        dstE_e = cnd_e ? rB_e : RNONE;
      I_CALL, I_RET, I_PUSH, I_POP:  dstE_e = RRSP;
      default:                       dstE_e = RNONE;
    endcase
    dstm_e = (icode_e == I_MRMOV || icode_e == I_POP) ? rA_e : RNONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zf <= 1'b1;
      sf <= 1'b0;
      of <= 1'b0;
    end else if (set_cc) begin
      zf <= (valE_e == '0);
      sf <= valE_e[W-1];
      of <= new_of;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bubble_m) begin
      stat_m  <= S_AOK;
      icode_m <= I_NOP;
      cnd_m   <= 1'b0;
      valE_m  <= '0;
      valA_m  <= '0;
      dstE_m  <= RNONE;
      dstM_m  <= RNONE;
    end else begin
      stat_m  <= stat_e;
      icode_m <= icode_e;
      cnd_m   <= cnd_e;
      valE_m  <= valE_e;
      valA_m  <= valA_e;
      dstE_m  <= dstE_e;
      dstM_m  <= dstm_e;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Randomized and directed bench for execute_stage against an arithmetic reference model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst, bubble_m;
  logic [2:0]  stat_e, m_stat_in, w_stat_in;
  logic [3:0]  icode_e, ifun_e, rA_e, rB_e;
  logic [63:0] valA_e, valB_e, valc_e;
  logic [63:0] valE_e, valE_m, valA_m;
  logic [3:0]  dstE_e, icode_m, dstE_m, dstM_m;
  logic        cnd_e, zf, sf, of, cnd_m;
  logic [2:0]  stat_m;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model condition codes
  logic mzf, msf, mof;

  execute_stage dut (
    .clk(clk), .rst(rst), .stat_e(stat_e), .icode_e(icode_e), .ifun_e(ifun_e),
    .rA_e(rA_e), .rB_e(rB_e), .valA_e(valA_e), .valB_e(valB_e), .valc_e(valc_e),
    .m_stat_in(m_stat_in), .w_stat_in(w_stat_in), .bubble_m(bubble_m),
    .valE_e(valE_e), .dstE_e(dstE_e), .cnd_e(cnd_e), .zf(zf), .sf(sf), .of(of),
    .stat_m(stat_m), .icode_m(icode_m), .cnd_m(cnd_m), .valE_m(valE_m),
    .valA_m(valA_m), .dstE_m(dstE_m), .dstM_m(dstM_m)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic is_fault(input logic [2:0] s);
    return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
  endfunction

  // Apply one E-stage instruction, check the combinational outputs, clock it, then check M and CC.
  task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic [2:0] ms, input logic [2:0] ws,
                       input logic bub, input logic rs);
    logic [63:0] ev;
    logic [64:0] wide;
    logic [3:0]  ed, emd;
    logic        ec, no, setcc;
    stat_e = st; icode_e = ic; ifun_e = fn; rA_e = ra; rB_e = rb;
    valA_e = a; valB_e = b; valc_e = c; m_stat_in = ms; w_stat_in = ws;
    bubble_m = bub; rst = rs;

    no = 1'b0;
    wide = '0;
    case (ic)
      4'h2: ev = a;
      4'h3: ev = c;
      4'h4, 4'h5: ev = b + c;
      4'h6: begin
        case (fn)
          4'h1: begin
            ev = b - a;
            wide = {b[63], b} - {a[63], a};
            no = wide[64] ^ wide[63];
          end
          4'h2: ev = a & b;
          4'h3: ev = a ^ b;
          default: begin
            ev = a + b;
            wide = {a[63], a} + {b[63], b};
            no = wide[64] ^ wide[63];
          end
        endcase
      end
      4'h8, 4'hA: ev = b - 64'd8;
      4'h9, 4'hB: ev = b + 64'd8;
      default: ev = 64'd0;
    endcase

    case (fn)
      4'h0: ec = 1'b1;
      4'h1: ec = (msf ^ mof) | mzf;
      4'h2: ec = msf ^ mof;
      4'h3: ec = mzf;
      4'h4: ec = ~mzf;
      4'h5: ec = ~(msf ^ mof);
      4'h6: ec = ~(msf ^ mof) & ~mzf;
      default: ec = 1'b0;
    endcase
    if (!(ic == 4'h2 || ic == 4'h7)) ec = 1'b1;

    case (ic)
      4'h3, 4'h6: ed = rb;
      4'h2: ed = ec ? rb : 4'hF;
      4'h8, 4'h9, 4'hA, 4'hB: ed = 4'h4;
      default: ed = 4'hF;
    endcase
    emd = (ic == 4'h5 || ic == 4'hB) ? ra : 4'hF;
    setcc = (ic == 4'h6) && (st == 3'd1) && !is_fault(ms) && !is_fault(ws);

    #2;
    check("valE_e", valE_e, ev);
    check("dstE_e", {60'd0, dstE_e}, {60'd0, ed});
    check("cnd_e", {63'd0, cnd_e}, {63'd0, ec});

    @(posedge clk);
    #1;
    if (rs) begin
      mzf = 1'b1; msf = 1'b0; mof = 1'b0;
    end else if (setcc) begin
      mzf = (ev == 64'd0); msf = ev[63]; mof = no;
    end
    check("zf", {63'd0, zf}, {63'd0, mzf});
    check("sf", {63'd0, sf}, {63'd0, msf});
    check("of", {63'd0, of}, {63'd0, mof});
    if (rs || bub) begin
      st = 3'd1; ic = 4'h1; ec = 1'b0; ev = 64'd0; a = 64'd0; ed = 4'hF; emd = 4'hF;
    end
    check("stat_m", {61'd0, stat_m}, {61'd0, st});
    check("icode_m", {60'd0, icode_m}, {60'd0, ic});
    check("cnd_m", {63'd0, cnd_m}, {63'd0, ec});
    check("valE_m", valE_m, ev);
    check("valA_m", valA_m, a);
    check("dstE_m", {60'd0, dstE_m}, {60'd0, ed});
    check("dstM_m", {60'd0, dstM_m}, {60'd0, emd});
  endtask

  initial begin
    logic [63:0] ra64, rb64, rc64;
    logic [2:0]  st, ms, ws;
    logic [3:0]  fn;
    mzf = 1'b1; msf = 1'b0; mof = 1'b0;
    rst = 1'b1; bubble_m = 1'b0;
    stat_e = 3'd1; icode_e = 4'h1; ifun_e = 4'h0; rA_e = 4'hF; rB_e = 4'hF;
    valA_e = '0; valB_e = '0; valc_e = '0; m_stat_in = 3'd1; w_stat_in = 3'd1;
    @(posedge clk);
    #1;

    // Reset
    drive(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 64'd0, 3'd1, 3'd1, 1'b0, 1'b1);
    check("rst_zf", {63'd0, zf}, 64'd1);
    check("rst_icode_m", {60'd0, icode_m}, 64'd1);
    check("rst_dstE_m", {60'd0, dstE_m}, 64'hF);
    check("rst_valE_m", valE_m, 64'd0);

    // subq 5,5 -> zero
    drive(3'd1, 4'h6, 4'h1, 4'h1, 4'h3, 64'd5, 64'd5, 64'd0, 3'd1, 3'd1, 1'b0, 1'b0);
    check("sub_valE", valE_e, 64'd0);
    check("sub_zf", {63'd0, zf}, 64'd1);
    check("sub_of", {63'd0, of}, 64'd0);
    check("sub_dstE_m", {60'd0, dstE_m}, 64'd3);

    // cmovne / cmove with zf=1
    drive(3'd1, 4'h2, 4'h4, 4'h1, 4'h2, 64'd9, 64'd0, 64'd0, 3'd1, 3'd1, 1'b0, 1'b0);
    check("cmovne_cnd", {63'd0, cnd_e}, 64'd0);
    check("cmovne_dstE", {60'd0, dstE_e}, 64'hF);
    drive(3'd1, 4'h2, 4'h3, 4'h1, 4'h2, 64'd9, 64'd0, 64'd0, 3'd1, 3'd1, 1'b0, 1'b0);
    check("cmove_cnd", {63'd0, cnd_e}, 64'd1);
    check("cmove_dstE", {60'd0, dstE_e}, 64'd2);

    // Signed overflow on add
    drive(3'd1, 4'h6, 4'h0, 4'h1, 4'h3, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
          64'd0, 3'd1, 3'd1, 1'b0, 1'b0);
    check("addov_valE", valE_e, 64'hFFFF_FFFF_FFFF_FFFE);
    check("addov_sf", {63'd0, sf}, 64'd1);
    check("addov_of", {63'd0, of}, 64'd1);
    check("addov_zf", {63'd0, zf}, 64'd0);

    // OPq behind an ADR fault leaves CC alone
    drive(3'd1, 4'h6, 4'h1, 4'h1, 4'h3, 64'd5, 64'd5, 64'd0, 3'd3, 3'd1, 1'b0, 1'b0);
    check("inhibit_zf", {63'd0, zf}, 64'd0);
    check("inhibit_icode_m", {60'd0, icode_m}, 64'd6);

    // pushq with a bubble into M
    drive(3'd1, 4'hA, 4'h0, 4'h1, 4'h4, 64'd0, 64'h100, 64'd0, 3'd1, 3'd1, 1'b1, 1'b0);
    check("push_valE", valE_e, 64'hF8);
    check("push_dstE", {60'd0, dstE_e}, 64'd4);
    check("push_bub_icode_m", {60'd0, icode_m}, 64'd1);
    check("push_bub_dstE_m", {60'd0, dstE_m}, 64'hF);

    // Reset mid-stream and simultaneous with bubble
    drive(3'd1, 4'h6, 4'h0, 4'h1, 4'h3, 64'd1, 64'd2, 64'd0, 3'd1, 3'd1, 1'b1, 1'b1);
    check("rst_mid_icode_m", {60'd0, icode_m}, 64'd1);

    for (int i = 0; i < 400; i++) begin
      ra64 = {$urandom, $urandom};
      rb64 = ($urandom_range(0, 3) == 0) ? ra64 : {$urandom, $urandom};
      rc64 = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) ra64 = 64'h8000_0000_0000_0000 ^ {63'd0, ra64[0]};
      fn = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      st = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
      ms = ($urandom_range(0, 6) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
      ws = ($urandom_range(0, 6) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
      drive(st, 4'($urandom_range(0, 11)), fn, 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), ra64, rb64, rc64, ms, ws,
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
